// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared types and helpers for the BCD conversion scheduler.
// Holds the FSM encoding, datapath widths and the binary-to-BCD function.
package bcd_conv_scheduler_pkg;

  localparam int BIN_W = 10;
  localparam int BCD_W = 16;
  localparam int NDIG  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

  // Double-dabble: adjust every digit >= 5 by +3, then shift one bit in.
  function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [BIN_W-1:0] bin);
    logic [BCD_W+BIN_W-1:0] sh;
    sh = {{BCD_W{1'b0}}, bin};
    for (int i = 0; i < BIN_W; i++) begin
      for (int d = 0; d < NDIG; d++) begin
        if (sh[BIN_W+4*d +: 4] >= 4'd5) begin
          sh[BIN_W+4*d +: 4] = sh[BIN_W+4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[BIN_W +: BCD_W];
  endfunction

endpackage

// File: rtl/bcd_conv_scheduler_bin2bcd.sv
// Shared combinational 10-bit binary to 4-digit BCD converter.
module bcd_conv_scheduler_bin2bcd
  import bcd_conv_scheduler_pkg::*;
(
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd
);

  assign o_bcd = bin_to_bcd(i_bin);

endmodule

// File: rtl/bcd_conv_scheduler_digit_scanner.sv
// Time-multiplexed 4-digit scan of one BCD word with leading-zero blanking.
module bcd_conv_scheduler_digit_scanner
  import bcd_conv_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [BCD_W-1:0] i_word,
  output logic [NDIG-1:0]  o_digit_en,
  output logic [3:0]       o_digit_val,
  output logic             o_digit_blank
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;

  // Divider and digit index; the index advances each time the divider wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
      r_idx <= r_idx;
    end
  end

  // Digit select and blanking: a digit blanks when it and all higher digits are zero.
  always_comb begin
    o_digit_en    = 4'b0001 << r_idx;
    o_digit_val   = 4'h0;
    o_digit_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        o_digit_val   = i_word[3:0];
        o_digit_blank = 1'b0;
      end
      2'd1: begin
        o_digit_val   = i_word[7:4];
        o_digit_blank = (i_word[15:4] == 12'h000);
      end
      2'd2: begin
        o_digit_val   = i_word[11:8];
        o_digit_blank = (i_word[15:8] == 8'h00);
      end
      2'd3: begin
        o_digit_val   = i_word[15:12];
        o_digit_blank = (i_word[15:12] == 4'h0);
      end
      default: begin
        o_digit_val   = 4'h0;
        o_digit_blank = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter between the live
// result and the best-time record, with per-source result registers and display scan.
module bcd_conv_scheduler
  import bcd_conv_scheduler_pkg::*;
#(
  parameter int CONV_CYCLES = 1,
  parameter int SCAN_DIV    = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [BIN_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [BIN_W-1:0] req1_data,
  output logic             req1_ready,
  output logic             busy,
  output logic             done,
  output logic             done_src,
  output logic [BCD_W-1:0] bcd0,
  output logic [BCD_W-1:0] bcd1,
  input  logic             disp_sel,
  output logic [NDIG-1:0]  digit_en,
  output logic [3:0]       digit_val,
  output logic             digit_blank
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [BIN_W-1:0] r_operand;
  logic             r_src;
  logic             r_rr;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd0;
  logic [BCD_W-1:0] r_bcd1;
  logic             r_done;
  logic             r_done_src;
  logic             w_grant;
  logic             w_conv_last;
  logic [BCD_W-1:0] w_conv_bcd;
  logic [BCD_W-1:0] w_disp_word;

  assign w_conv_last = (r_cnt == CNT_W'(CONV_CYCLES - 1));

  // Arbitration, handshake and next-state; readys only ever rise in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          w_grant = r_rr;
        end else begin
          w_grant = req1_valid;
        end
        req0_ready = req0_valid & ~w_grant;
        req1_ready = req1_valid & w_grant;
        if (req0_valid || req1_valid) begin
          w_next_state = ST_CONV;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (w_conv_last) begin
          w_next_state = ST_CAPT;
        end else begin
          w_next_state = ST_CONV;
        end
      end
      ST_CAPT: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: result lands together with done so both are visible in CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_operand  <= '0;
      r_src      <= 1'b0;
      r_rr       <= 1'b0;
      r_cnt      <= '0;
      r_bcd0     <= '0;
      r_bcd1     <= '0;
      r_done     <= 1'b0;
      r_done_src <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            r_operand <= w_grant ? req1_data : req0_data;
            r_src     <= w_grant;
            r_cnt     <= '0;
          end
        end
        ST_CONV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_conv_last) begin
            if (r_src) begin
              r_bcd1 <= w_conv_bcd;
            end else begin
              r_bcd0 <= w_conv_bcd;
            end
            r_done     <= 1'b1;
            r_done_src <= r_src;
          end
        end
        ST_CAPT: r_rr <= ~r_src;
        default: r_rr <= r_rr;
      endcase
    end
  end

  bcd_conv_scheduler_bin2bcd u_conv (
    .i_bin (r_operand),
    .o_bcd (w_conv_bcd)
  );

  assign w_disp_word = disp_sel ? r_bcd1 : r_bcd0;

  bcd_conv_scheduler_digit_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_word        (w_disp_word),
    .o_digit_en    (digit_en),
    .o_digit_val   (digit_val),
    .o_digit_blank (digit_blank)
  );

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign done_src = r_done_src;
  assign bcd0     = r_bcd0;
  assign bcd1     = r_bcd1;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Self-checking bench: directed stimulus, scoreboard of expected conversions.
module tb_bcd_conv_scheduler;

  localparam int CONV_CYCLES = 1;
  localparam int SCAN_DIV    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [9:0]  req0_data = 10'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [9:0]  req1_data = 10'd0;
  logic        req1_ready;
  logic        busy;
  logic        done;
  logic        done_src;
  logic [15:0] bcd0;
  logic [15:0] bcd1;
  logic        disp_sel = 1'b0;
  logic [3:0]  digit_en;
  logic [3:0]  digit_val;
  logic        digit_blank;

  always #5 clk = ~clk;

  bcd_conv_scheduler #(
    .CONV_CYCLES (CONV_CYCLES),
    .SCAN_DIV    (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .busy        (busy),
    .done        (done),
    .done_src    (done_src),
    .bcd0        (bcd0),
    .bcd1        (bcd1),
    .disp_sel    (disp_sel),
    .digit_en    (digit_en),
    .digit_val   (digit_val),
    .digit_blank (digit_blank)
  );

  typedef struct {
    logic        src;
    logic [15:0] bcd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          acc_src[$];
  int          acc_cyc[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_bcd0 = 16'h0000;
  logic [15:0] m_bcd1 = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on handshake, pop and compare on done.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      m_bcd0 = 16'h0000;
      m_bcd1 = 16'h0000;
    end else begin
      if (req0_ready || req1_ready)
        check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, to_bcd(int'(req0_data)), cyc});
        acc_src.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, to_bcd(int'(req1_data)), cyc});
        acc_src.push_back(1);
        acc_cyc.push_back(cyc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.src) m_bcd1 = e.bcd;
          else m_bcd0 = e.bcd;
          check("done_src", 32'(done_src), 32'(e.src));
          check("done_latency", 32'(cyc - e.cyc), 32'(CONV_CYCLES + 1));
          check("bcd0_model", 32'(bcd0), 32'(m_bcd0));
          check("bcd1_model", 32'(bcd1), 32'(m_bcd1));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check("busy_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic src, input int val);
    int k;
    @(posedge clk); #1;
    if (src) begin req1_valid = 1'b1; req1_data = 10'(val); end
    else begin req0_valid = 1'b1; req0_data = 10'(val); end
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (src ? req1_ready : req0_ready) break;
    end
    check("ready_seen", 32'(src ? req1_ready : req0_ready), 32'd1);
    check("ready_same_cycle", 32'(k), 32'd0);
    @(posedge clk); #1;
    if (src) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic scan_check(input logic [15:0] word);
    logic [3:0] prev;
    int k;
    prev = digit_en;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (digit_en == 4'b0001 && prev == 4'b1000) break;
      prev = digit_en;
    end
    check("scan_wrap_found", 32'(digit_en), 32'h1);
    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < SCAN_DIV; j++) begin
        if (!(d == 0 && j == 0)) @(negedge clk);
        check("digit_en", 32'(digit_en), 32'(4'b0001 << d));
        check("digit_val", 32'(digit_val), 32'((word >> (4 * d)) & 16'h000F));
        check("digit_blank", 32'(digit_blank), 32'((d > 0) && ((word >> (4 * d)) == 16'h0000)));
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  k;
    logic d0, d1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_src", 32'(done_src), 32'd0);
    check("rst_bcd0", 32'(bcd0), 32'h0);
    check("rst_bcd1", 32'(bcd1), 32'h0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'h1);
    scan_check(16'h0000);

    // Single request from source 0
    send(1'b0, 345);
    check("t1_bcd0", 32'(bcd0), 32'h0345);
    check("t1_bcd1", 32'(bcd1), 32'h0000);

    // Simultaneous requests from reset: source 0 first, then source 1
    do_reset();
    acc_src.delete();
    acc_cyc.delete();
    d0 = 1'b0;
    d1 = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 10'd12;
    req1_valid = 1'b1; req1_data = 10'd999;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) d0 = 1'b1;
      if (req1_valid && req1_ready) d1 = 1'b1;
      @(posedge clk); #1;
      if (d0) req0_valid = 1'b0;
      if (d1) req1_valid = 1'b0;
      if (!req0_valid && !req1_valid) break;
    end
    wait_idle();
    check("t2_acc_count", 32'(acc_src.size()), 32'd2);
    if (acc_src.size() >= 2) begin
      check("t2_first_src", 32'(acc_src[0]), 32'd0);
      check("t2_second_src", 32'(acc_src[1]), 32'd1);
      check("t2_second_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(CONV_CYCLES + 2));
    end
    check("t2_bcd0", 32'(bcd0), 32'h0012);
    check("t2_bcd1", 32'(bcd1), 32'h0999);

    // Round-robin: req0 held valid, req1 raised mid-conversion
    acc_src.delete();
    acc_cyc.delete();
    d1 = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 10'd7;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) d1 = 1'b1;
      if (acc_src.size() >= 3) break;
      @(posedge clk); #1;
      if (k == 0) begin req1_valid = 1'b1; req1_data = 10'd500; end
      if (d1) req1_valid = 1'b0;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("t3_acc_count", 32'(acc_src.size()), 32'd3);
    if (acc_src.size() >= 3) begin
      check("t3_order0", 32'(acc_src[0]), 32'd0);
      check("t3_order1", 32'(acc_src[1]), 32'd1);
      check("t3_order2", 32'(acc_src[2]), 32'd0);
    end
    check("t3_bcd1", 32'(bcd1), 32'h0500);

    // Boundaries
    send(1'b0, 0);
    check("b_zero", 32'(bcd0), 32'h0000);
    send(1'b1, 1023);
    check("b_max", 32'(bcd1), 32'h1023);
    send(1'b0, 1000);
    check("b_1000", 32'(bcd0), 32'h1000);
    check("b_1000_other", 32'(bcd1), 32'h1023);

    // Reset during CONV
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 10'd200;
    @(negedge clk);
    check("r_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("r_busy_conv", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done), 32'd0);
    check("r_bcd0", 32'(bcd0), 32'h0);
    check("r_bcd1", 32'(bcd1), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("r_no_done", 32'(done), 32'd0);
    end
    send(1'b0, 345);
    check("r_after_bcd0", 32'(bcd0), 32'h0345);
    check("r_after_bcd1", 32'(bcd1), 32'h0000);

    // Display scan
    send(1'b0, 45);
    disp_sel = 1'b0;
    scan_check(16'h0045);
    send(1'b1, 1023);
    @(posedge clk); #1;
    disp_sel = 1'b1;
    scan_check(16'h1023);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
